controle_ventoinha_rampa: RTL and testbench

Parametrised next-generation fan PWM controller. It converts an N-bit fan level into a PWM duty with a configurable period, and adds three behaviours:
- level 0 means fan fully off;
- a full-duty kick-start when spinning up from rest;
- slew-limited duty ramping between levels.

All duty changes take effect only at PWM period boundaries, so the output never glitches. It sits between the thermal/control FSM and the fan driver pin.

---
 rtl/controle_ventoinha_rampa.sv | 140 ++++++++++++++
 tb/tb_controle_ventoinha_rampa.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/controle_ventoinha_rampa.sv
// Fan PWM controller with level-to-width mapping, kick-start from rest and
// slew-limited ramping. Every width/state change is taken on the last cycle
// of a PWM period, so the pin never sees a truncated or stretched pulse.
module controle_ventoinha_rampa #(
    parameter int PERIODO       = 2500,
    parameter int NIVEL_BITS    = 3,
    parameter int PASSO_RAMPA   = 125,
    parameter int KICK_PERIODOS = 4000
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NIVEL_BITS-1:0]            nivel,
    output logic                             pwm,
    output logic [$clog2(PERIODO+1)-1:0]     largura_atual,
    output logic                             em_rampa,
    output logic                             em_partida,
    output logic                             fim_periodo
);

    localparam int LW      = $clog2(PERIODO + 1);
    localparam int CW      = $clog2(PERIODO);
    localparam int KW      = (KICK_PERIODOS > 2) ? $clog2(KICK_PERIODOS) : 1;
    localparam int NMAX    = (1 << NIVEL_BITS) - 1;
    localparam int UNIDADE = PERIODO / NMAX;

    localparam logic [LW-1:0] L_CHEIA  = LW'(PERIODO);
    // A step larger than the period behaves exactly like a step of one period.
    localparam logic [LW-1:0] L_PASSO  = LW'((PASSO_RAMPA > PERIODO) ? PERIODO : PASSO_RAMPA);
    localparam logic [CW-1:0] CNT_MAX  = CW'(PERIODO - 1);
    localparam logic [KW-1:0] KICK_INI = KW'((KICK_PERIODOS > 0) ? KICK_PERIODOS - 1 : 0);

    localparam logic [1:0] DESLIGADO = 2'd0;
    localparam logic [1:0] PARTIDA   = 2'd1;
    localparam logic [1:0] OPERANDO  = 2'd2;

    logic [CW-1:0] r_cnt;
    logic [LW-1:0] r_largura;
    logic [LW-1:0] r_alvo;
    logic [1:0]    r_estado;
    logic [KW-1:0] r_kick;
    logic          r_pwm;

    logic          w_fim;
    logic [CW-1:0] w_cnt_prox;
    logic [LW-1:0] w_alvo;
    logic [LW-1:0] w_dist;
    logic [LW-1:0] w_passo;
    logic [LW-1:0] w_largura_prox;
    logic [1:0]    w_estado_prox;
    logic [KW-1:0] w_kick_prox;

    // Level to target width: 0 is off, full scale is exactly the period.
    function automatic logic [LW-1:0] largura_alvo(input logic [NIVEL_BITS-1:0] n);
        if (n == '0)
            return '0;
        else if (n == '1)
            return L_CHEIA;
        else
            return LW'(int'(n) * UNIDADE);
    endfunction

    // Counter wrap, ramp step and next state, all evaluated for the boundary cycle.
    always_comb begin
        w_fim          = (r_cnt == CNT_MAX);
        w_cnt_prox     = w_fim ? '0 : r_cnt + 1'b1;
        w_alvo         = largura_alvo(nivel);
        w_dist         = (w_alvo >= r_largura) ? (w_alvo - r_largura) : (r_largura - w_alvo);
        w_passo        = (w_dist < L_PASSO) ? w_dist : L_PASSO;
        w_largura_prox = r_largura;
        w_estado_prox  = r_estado;
        w_kick_prox    = r_kick;
        if (w_fim) begin
            case (r_estado)
                DESLIGADO: begin
                    if (w_alvo != '0) begin
                        if (KICK_PERIODOS > 0) begin
                            w_estado_prox  = PARTIDA;
                            w_largura_prox = L_CHEIA;
                            w_kick_prox    = KICK_INI;
                        end else begin
                            w_estado_prox  = OPERANDO;
                            w_largura_prox = (w_alvo < L_PASSO) ? w_alvo : L_PASSO;
                        end
                    end
                end
                PARTIDA: begin
                    if (w_alvo == '0) begin
                        w_estado_prox  = DESLIGADO;
                        w_largura_prox = '0;
                    end else if (r_kick == '0) begin
                        w_estado_prox  = OPERANDO;
                        w_largura_prox = w_alvo;
                    end else begin
                        w_kick_prox    = r_kick - 1'b1;
                    end
                end
                OPERANDO: begin
                    // Step is bounded by the distance, so neither direction can wrap.
                    if (w_alvo >= r_largura)
                        w_largura_prox = r_largura + w_passo;
                    else
                        w_largura_prox = r_largura - w_passo;
                    if (w_largura_prox == '0)
                        w_estado_prox = DESLIGADO;
                end
                default: begin
                    w_estado_prox  = DESLIGADO;
                    w_largura_prox = '0;
                end
            endcase
        end
    end

    // State, counter and registered PWM pin; reset forces the pin low at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_largura <= '0;
            r_alvo    <= '0;
            r_estado  <= DESLIGADO;
            r_kick    <= '0;
            r_pwm     <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_prox;
            r_largura <= w_largura_prox;
            r_estado  <= w_estado_prox;
            r_kick    <= w_kick_prox;
            if (w_fim)
                r_alvo <= w_alvo;
            r_pwm     <= (LW'(w_cnt_prox) < w_largura_prox);
        end
    end

    assign pwm           = r_pwm;
    assign largura_atual = r_largura;
    assign fim_periodo   = w_fim;
    assign em_partida    = (r_estado == PARTIDA);
    assign em_rampa      = (r_estado == OPERANDO) && (r_largura != r_alvo);

endmodule

// File: tb/tb_controle_ventoinha_rampa.sv
// Bench for controle_ventoinha_rampa: fixed scenario table, hand-written
// reset/boundary sequences and randomized levels against a period-level model.
module tb_controle_ventoinha_rampa;

    localparam int PER   = 20;
    localparam int NB    = 2;
    localparam int PASSO = 4;
    localparam int KICK  = 2;
    localparam int LWT   = $clog2(PER + 1);

    logic            clock;
    logic            reset;
    logic [NB-1:0]   nivel;
    logic            pwm;
    logic [LWT-1:0]  largura_atual;
    logic            em_rampa;
    logic            em_partida;
    logic            fim_periodo;

    controle_ventoinha_rampa #(
        .PERIODO(PER), .NIVEL_BITS(NB), .PASSO_RAMPA(PASSO), .KICK_PERIODOS(KICK)
    ) dut (
        .clock(clock), .reset(reset), .nivel(nivel), .pwm(pwm),
        .largura_atual(largura_atual), .em_rampa(em_rampa),
        .em_partida(em_partida), .fim_periodo(fim_periodo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode 0 = off, 1 = kick, 2 = running
    int m_cnt, m_w, m_mode, m_kick, m_alvo, m_pwm;

    typedef struct {
        int nivel;
        int largura;
        int partida;
        int rampa;
    } vetor_t;
    vetor_t tabela[22];

    task automatic chk(input string nome, input int atual, input int esperado);
        n_checks++;
        if (atual != esperado) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nome, atual, esperado, $time);
        end
    endtask

    function automatic int alvo_de(input int n);
        if (n == 0) return 0;
        if (n == (1 << NB) - 1) return PER;
        return n * (PER / ((1 << NB) - 1));
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_w = 0; m_mode = 0; m_kick = 0; m_alvo = 0; m_pwm = 0;
    endtask

    task automatic model_boundary(input int n);
        int a;
        a = alvo_de(n);
        if (m_mode == 0) begin
            if (a > 0) begin
                if (KICK > 0) begin m_mode = 1; m_w = PER; m_kick = KICK - 1; end
                else begin m_mode = 2; m_w = (a < PASSO) ? a : PASSO; end
            end
        end else if (m_mode == 1) begin
            if (a == 0) begin m_mode = 0; m_w = 0; end
            else if (m_kick == 0) begin m_mode = 2; m_w = a; end
            else m_kick = m_kick - 1;
        end else begin
            if (a > m_w) m_w = (m_w + PASSO > a) ? a : m_w + PASSO;
            else         m_w = (m_w - PASSO < a) ? a : m_w - PASSO;
            if (m_w == 0) m_mode = 0;
        end
        m_alvo = a;
    endtask

    task automatic tick();
        if (m_cnt == PER - 1) begin
            model_boundary(int'(nivel));
            m_cnt = 0;
        end else begin
            m_cnt = m_cnt + 1;
        end
        m_pwm = (m_cnt < m_w) ? 1 : 0;
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pwm"},      int'(pwm),           m_pwm);
        chk({tag, ".largura"},  int'(largura_atual), m_w);
        chk({tag, ".fim"},      int'(fim_periodo),   (m_cnt == PER - 1) ? 1 : 0);
        chk({tag, ".partida"},  int'(em_partida),    (m_mode == 1) ? 1 : 0);
        chk({tag, ".rampa"},    int'(em_rampa),      (m_mode == 2 && m_w != m_alvo) ? 1 : 0);
    endtask

    initial begin
        tabela[0]  = '{2, 20, 1, 0};
        tabela[1]  = '{2, 12, 0, 0};
        tabela[2]  = '{3, 16, 0, 1};
        tabela[3]  = '{3, 20, 0, 0};
        tabela[4]  = '{1, 16, 0, 1};
        tabela[5]  = '{1, 12, 0, 1};
        tabela[6]  = '{1,  8, 0, 1};
        tabela[7]  = '{1,  6, 0, 0};
        tabela[8]  = '{0,  2, 0, 1};
        tabela[9]  = '{0,  0, 0, 0};
        tabela[10] = '{1, 20, 1, 0};
        tabela[11] = '{1, 20, 1, 0};
        tabela[12] = '{1,  6, 0, 0};
        tabela[13] = '{0,  2, 0, 1};
        tabela[14] = '{0,  0, 0, 0};
        tabela[15] = '{3, 20, 1, 0};
        tabela[16] = '{0,  0, 0, 0};
        tabela[17] = '{0,  0, 0, 0};
        tabela[18] = '{2, 20, 1, 0};
        tabela[19] = '{2, 20, 1, 0};
        tabela[20] = '{2, 12, 0, 0};
        tabela[21] = '{3, 16, 0, 1};

        reset = 1'b0;
        nivel = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset.pwm", int'(pwm), 0);
        chk("reset.largura", int'(largura_atual), 0);
        chk("reset.partida", int'(em_partida), 0);
        chk("reset.fim", int'(fim_periodo), 0);
        reset = 1'b1;

        // First boundary 19 cycles after release; level change mid-period waits for it
        for (int i = 1; i <= PER; i++) begin
            if (i == 10) nivel = 2'd2;
            tick();
            check_all("inicio");
            if (i == 18) chk("inicio.fim18", int'(fim_periodo), 0);
            if (i == 19) begin
                chk("inicio.fim19", int'(fim_periodo), 1);
                chk("inicio.largura_antes", int'(largura_atual), 0);
            end
        end
        chk("kick.largura", int'(largura_atual), 20);
        chk("kick.partida", int'(em_partida), 1);
        chk("kick.pwm", int'(pwm), 1);

        // Period-by-period scenario table
        for (int r = 0; r < 22; r++) begin
            nivel = NB'(tabela[r].nivel);
            for (int c = 0; c < PER; c++) begin
                tick();
                check_all("tabela");
            end
            chk($sformatf("tab%0d.largura", r), int'(largura_atual), tabela[r].largura);
            chk($sformatf("tab%0d.partida", r), int'(em_partida), tabela[r].partida);
            chk($sformatf("tab%0d.rampa", r), int'(em_rampa), tabela[r].rampa);
        end

        // Asynchronous reset in the middle of a ramp period at width 16
        for (int c = 0; c < 7; c++) begin
            tick();
            check_all("prereset");
        end
        chk("prereset.pwm", int'(pwm), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async.pwm", int'(pwm), 0);
        chk("async.largura", int'(largura_atual), 0);
        chk("async.rampa", int'(em_rampa), 0);
        chk("async.partida", int'(em_partida), 0);
        chk("async.fim", int'(fim_periodo), 0);
        model_reset();
        nivel = '0;
        @(posedge clock);
        #1;
        check_all("emreset");
        reset = 1'b1;
        for (int i = 1; i <= PER; i++) begin
            tick();
            check_all("posreset");
            if (i == 18) chk("posreset.fim18", int'(fim_periodo), 0);
            if (i == 19) chk("posreset.fim19", int'(fim_periodo), 1);
        end

        // Randomized levels changing at arbitrary cycles
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 14) == 0) nivel = NB'($urandom_range(0, 3));
            tick();
            check_all("aleatorio");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
